// File: rtl/fetch_pkg.sv
// ==== fetch_pkg: shared types for the instruction-fetch stage (rev 1.0) ====
`default_nettype none

package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fq_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ==== fetch_queue: circular FIFO of fetched entries, push+pop allowed when full (rev 1.0) ====
`default_nettype none

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int FQ_DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      push_i,
    input  fq_entry_t entry_i,
    input  logic      pop_i,
    input  logic      flush_i,
    output logic      full_o,
    output logic      empty_o,
    output fq_entry_t head_o
);

    localparam int             PW      = $clog2(FQ_DEPTH);
    localparam logic [PW-1:0]  PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]    CNT_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]    CNT_MAX = (PW+1)'(FQ_DEPTH);

    fq_entry_t     mem_q [FQ_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          w_do_push;
    logic          w_do_pop;

    assign full_o    = (count_q == CNT_MAX);
    assign empty_o   = (count_q == '0);
    assign head_o    = mem_q[rd_ptr_q];
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_comb begin
        count_d = count_q;
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!w_do_push && w_do_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed while count_q is non-zero.
    always_ff @(posedge clk_i) begin
        if (w_do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ==== fetch_unit: PC owner, fault detection and fetch-queue control feeding decode (rev 1.0) ====
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 4096,
    parameter int          FQ_DEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_pc_plus4_o,
    output logic        out_fault_o
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  last_pc_q;
    logic         w_fault;
    logic         w_pop;
    logic         w_push;
    logic         w_full;
    logic         w_empty;
    fq_entry_t    w_entry;
    fq_entry_t    w_head;

    assign imem_addr_o = pc_q;
    assign w_fault     = (pc_q[1:0] != 2'b00) || (pc_q >= 32'(IMEM_BYTES));
    assign out_valid_o = !w_empty;
    assign w_pop       = out_valid_o && out_ready_i;
    assign w_push      = (state_q == FETCH) && !redirect_i && (!w_full || w_pop);

    always_comb begin
        w_entry.pc    = pc_q;
        w_entry.instr = w_fault ? NOP_INSTR : imem_instr_i;
        w_entry.fault = w_fault;
    end

    fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (w_push),
        .entry_i (w_entry),
        .pop_i   (w_pop && !redirect_i),
        .flush_i (redirect_i),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

    // PC fields keep the last delivered value while the queue is empty.
    assign out_instr_o    = out_valid_o ? w_head.instr : NOP_INSTR;
    assign out_fault_o    = out_valid_o && w_head.fault;
    assign out_pc_o       = out_valid_o ? w_head.pc : last_pc_q;
    assign out_pc_plus4_o = out_pc_o + 32'd4;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            last_pc_q <= '0;
        end else begin
            if (redirect_i) begin
                pc_q    <= redirect_pc_i;
                state_q <= FETCH;
            end else if (w_push) begin
                if (w_fault) begin
                    state_q <= HALT;
                end else begin
                    pc_q <= pc_q + 32'd4;
                end
            end
            if (out_valid_o) begin
                last_pc_q <= w_head.pc;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ==== tb_fetch_unit: scoreboard bench for fetch_unit (rev 1.0) ====
`default_nettype none

module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        out_fault;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Memory image: each word is its own address XOR a marker.
    assign imem_instr = 32'hA500_0000 ^ imem_addr;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (4096),
        .FQ_DEPTH   (2)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .imem_addr_o    (imem_addr),
        .imem_instr_i   (imem_instr),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_instr_o    (out_instr),
        .out_pc_o       (out_pc),
        .out_pc_plus4_o (out_pc4),
        .out_fault_o    (out_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t ok_e(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = 32'hA500_0000 ^ pc;
        e.fault = 1'b0;
        return e;
    endfunction

    function automatic exp_t flt_e(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = 32'h0000_0013;
        e.fault = 1'b1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
    endtask

    // Monitor: every accepted head must be the next expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop: got pc %h expected no delivery", out_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_instr", out_instr, e.instr);
                chk("out_pc_plus4", out_pc4, e.pc + 32'd4);
                chk("out_fault", {31'b0, out_fault}, {31'b0, e.fault});
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        out_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_fault", {31'b0, out_fault}, 32'd0);
        chk("rst_instr", out_instr, 32'h0000_0013);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_pc_plus4", out_pc4, 32'h4);
        chk("rst_imem_addr", imem_addr, 32'h0);

        // Streaming with ready high: 0,4,8,12 back to back
        sb.push_back(ok_e(32'h0));
        sb.push_back(ok_e(32'h4));
        sb.push_back(ok_e(32'h8));
        sb.push_back(ok_e(32'hC));
        rst_n = 1'b1;
        chk("c0_imem_addr", imem_addr, 32'h0);
        chk("c0_valid", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_valid", {31'b0, out_valid}, 32'd1);
        end
        tick();
        out_ready = 1'b0;
        chk("stream_drained", sb.size(), 32'd0);

        // Asynchronous reset mid-cycle with valid high
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_imem_addr", imem_addr, 32'h0);

        // Backpressure: ready low for 5 cycles after release
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i >= 1) chk("bp_imem_addr", imem_addr, 32'h8);
        end
        chk("bp_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_head_pc", out_pc, 32'h0);
        sb.push_back(ok_e(32'h0));
        sb.push_back(ok_e(32'h4));
        sb.push_back(ok_e(32'h8));
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        chk("bp_drained", sb.size(), 32'd0);

        // Redirect to 0x40 while full and a pop is offered
        out_ready = 1'b1;
        do_redirect(32'h40);
        chk("redir_n1_valid", {31'b0, out_valid}, 32'd0);
        chk("redir_n1_imem_addr", imem_addr, 32'h40);
        sb.push_back(ok_e(32'h40));
        sb.push_back(ok_e(32'h44));
        tick();
        chk("redir_n2_valid", {31'b0, out_valid}, 32'd1);
        chk("redir_n2_pc", out_pc, 32'h40);
        tick();
        tick();
        out_ready = 1'b0;
        chk("redir_drained", sb.size(), 32'd0);

        // Misaligned redirect: single fault entry then HALT
        do_redirect(32'h102);
        chk("mis_n1_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("mis_fault", {31'b0, out_fault}, 32'd1);
        sb.push_back(flt_e(32'h102));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_valid", {31'b0, out_valid}, 32'd0);
            chk("halt_imem_addr", imem_addr, 32'h102);
        end
        sb.push_back(ok_e(32'h0));
        sb.push_back(ok_e(32'h4));
        do_redirect(32'h0);
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        chk("resume_drained", sb.size(), 32'd0);

        // Sequential fetch off the end of the memory window
        sb.push_back(ok_e(32'hFF8));
        sb.push_back(ok_e(32'hFFC));
        sb.push_back(flt_e(32'h1000));
        out_ready = 1'b1;
        do_redirect(32'hFF8);
        for (int i = 0; i < 4; i++) tick();
        chk("end_valid", {31'b0, out_valid}, 32'd0);
        chk("end_pc_hold", out_pc, 32'h1000);
        chk("end_pc_plus4", out_pc4, 32'h1004);
        chk("end_instr", out_instr, 32'h0000_0013);
        chk("end_imem_addr", imem_addr, 32'h1000);
        tick();
        chk("end_halt_valid", {31'b0, out_valid}, 32'd0);
        chk("end_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
